multichannel_rd_rr_arbiter: RTL and testbench

//  Parametrised N-channel DDR read arbiter between the per-channel read controllers and the AXI read master.
//  It grants one channel at a time with a rotating round-robin pointer and registers that channel's address and length.
//  It issues one valid/ready read command, then holds the grant until the master reports burst completion.

---
 rtl/ddr_arb_pkg.sv | 24 ++
 rtl/rr_pick.sv | 46 ++++
 rtl/multichannel_rd_rr_arbiter.sv | 140 ++++++++++++++
 tb/tb_multichannel_rd_rr_arbiter.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_arb_pkg.sv
// Shared definitions for the DDR read/write arbiters: one-hot FSM encoding
// and a one-hot to index helper.
package ddr_arb_pkg;

   localparam int ST_W   = 3;
   localparam int MAX_CH = 16;

   typedef logic [ST_W-1:0] arb_state_t;

   localparam arb_state_t ST_IDLE      = 3'b001;
   localparam arb_state_t ST_ISSUE     = 3'b010;
   localparam arb_state_t ST_WAIT_DONE = 3'b100;

   // OR of the indices of all set bits; exact for a one-hot or zero input
   function automatic logic [3:0] onehot2idx(input logic [MAX_CH-1:0] oh);
      logic [3:0] idx;
      idx = '0;
      for (int i = 0; i < MAX_CH; i++) begin
         if (oh[i]) idx = idx | 4'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set request at or after ptr,
// wrapping around, via a masked copy plus a double-width priority encoder.
module rr_pick #(
   parameter int CH_NUM = 4,
   localparam int PW    = $clog2(CH_NUM)
) (
   input  logic [CH_NUM-1:0] req_i,
   input  logic [PW-1:0]     ptr_i,
   output logic              any_o,
   output logic [PW-1:0]     idx_o,
   output logic [CH_NUM-1:0] onehot_o
);

   localparam int DW  = 2 * CH_NUM;
   localparam int DPW = $clog2(DW);

   logic [CH_NUM-1:0] mask;
   logic [DW-1:0]     dbl;
   logic [DPW-1:0]    pos;

   always_comb begin
      mask = '0;
      for (int i = 0; i < CH_NUM; i++) begin
         mask[i] = (int'(ptr_i) <= i);
      end
   end

   // Lower half holds only requests at/after ptr, so it wins when non-empty
   assign dbl = {req_i, req_i & mask};

   always_comb begin
      pos = '0;
      for (int i = DW - 1; i >= 0; i--) begin
         if (dbl[i]) pos = DPW'(i);
      end
   end

   always_comb begin
      if (pos >= DPW'(CH_NUM)) idx_o = PW'(pos - DPW'(CH_NUM));
      else                     idx_o = PW'(pos);
   end

   assign any_o    = |req_i;
   assign onehot_o = any_o ? (CH_NUM'(1) << idx_o) : '0;

endmodule

// File: rtl/multichannel_rd_rr_arbiter.sv
// N-channel DDR read arbiter: round-robin grant, one registered valid/ready
// read command per grant, grant held until the master reports burst done.
module multichannel_rd_rr_arbiter
   import ddr_arb_pkg::*;
#(
   parameter int CH_NUM = 4,
   parameter int ADDR_W = 30,
   parameter int LEN_W  = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [CH_NUM-1:0]        rd_req,
   input  logic [CH_NUM*ADDR_W-1:0] rd_addr,
   input  logic [CH_NUM*LEN_W-1:0]  rd_len,
   output logic [CH_NUM-1:0]        rd_grant,
   output logic                     axi_rd_start,
   input  logic                     axi_rd_ready,
   output logic [ADDR_W-1:0]        axi_rd_addr,
   output logic [LEN_W-1:0]         axi_rd_len,
   input  logic                     rd_done,
   output logic                     busy,
   output logic                     proto_err
);

   localparam int PW = $clog2(CH_NUM);

   arb_state_t          state_q, state_d;
   logic [PW-1:0]       ptr_q, ptr_d;
   logic [CH_NUM-1:0]   grant_q, grant_d;
   logic                start_q, start_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [LEN_W-1:0]    len_q, len_d;
   logic                busy_q, busy_d;
   logic                err_q, err_d;

   logic                pick_any;
   logic [PW-1:0]       pick_idx;
   logic [CH_NUM-1:0]   pick_oh;
   logic [ADDR_W-1:0]   addr_sel;
   logic [LEN_W-1:0]    len_sel;
   logic [PW-1:0]       cur_idx, ptr_nxt;
   logic                accept;

   rr_pick #(.CH_NUM(CH_NUM)) u_pick (
      .req_i    (rd_req),
      .ptr_i    (ptr_q),
      .any_o    (pick_any),
      .idx_o    (pick_idx),
      .onehot_o (pick_oh)
   );

   always_comb begin
      addr_sel = '0;
      len_sel  = '0;
      for (int i = 0; i < CH_NUM; i++) begin
         if (PW'(i) == pick_idx) begin
            addr_sel = rd_addr[i*ADDR_W +: ADDR_W];
            len_sel  = rd_len[i*LEN_W +: LEN_W];
         end
      end
   end

   // Pointer advances past the channel that just finished its burst
   assign cur_idx = PW'(onehot2idx(MAX_CH'(grant_q)));
   assign ptr_nxt = (cur_idx == PW'(CH_NUM - 1)) ? '0 : cur_idx + 1'b1;
   assign accept  = start_q && axi_rd_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         ptr_q   <= '0;
         grant_q <= '0;
         start_q <= 1'b0;
         addr_q  <= '0;
         len_q   <= '0;
         busy_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         grant_q <= grant_d;
         start_q <= start_d;
         addr_q  <= addr_d;
         len_q   <= len_d;
         busy_q  <= busy_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:      if (pick_any) state_d = ST_ISSUE;
         ST_ISSUE:     if (accept)   state_d = ST_WAIT_DONE;
         ST_WAIT_DONE: if (rd_done)  state_d = ST_IDLE;
         default:                    state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      ptr_d   = ptr_q;
      grant_d = grant_q;
      start_d = start_q;
      addr_d  = addr_q;
      len_d   = len_q;
      case (state_q)
         ST_IDLE: begin
            if (pick_any) begin
               grant_d = pick_oh;
               addr_d  = addr_sel;
               len_d   = len_sel;
               start_d = 1'b1;
            end
         end
         ST_ISSUE: begin
            if (accept) start_d = 1'b0;
         end
         ST_WAIT_DONE: begin
            if (rd_done) begin
               grant_d = '0;
               ptr_d   = ptr_nxt;
            end
         end
         default: begin
            grant_d = '0;
            start_d = 1'b0;
         end
      endcase
      busy_d = (state_d != ST_IDLE);
      err_d  = err_q | (rd_done && (state_q != ST_WAIT_DONE));
   end

   assign rd_grant     = grant_q;
   assign axi_rd_start = start_q;
   assign axi_rd_addr  = addr_q;
   assign axi_rd_len   = len_q;
   assign busy         = busy_q;
   assign proto_err    = err_q;

endmodule

// File: tb/tb_multichannel_rd_rr_arbiter.sv
// Randomized and directed bench for the read arbiter, 4- and 8-channel builds,
// against a cycle-level reference model of the arbitration rules.
module tb_multichannel_rd_rr_arbiter;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // 4-channel instance
   logic [3:0]   req4;
   logic [119:0] addr4;
   logic [31:0]  len4;
   logic         ready4, done4;
   logic [3:0]   g4;
   logic         st4, busy4, err4;
   logic [29:0]  a4;
   logic [7:0]   l4;

   // 8-channel instance
   logic [7:0]   req8;
   logic [239:0] addr8;
   logic [63:0]  len8;
   logic         ready8, done8;
   logic [7:0]   g8;
   logic         st8, busy8, err8;
   logic [29:0]  a8;
   logic [7:0]   l8;

   multichannel_rd_rr_arbiter #(.CH_NUM(4), .ADDR_W(30), .LEN_W(8)) dut4 (
      .clk(clk), .rst(rst), .rd_req(req4), .rd_addr(addr4), .rd_len(len4),
      .rd_grant(g4), .axi_rd_start(st4), .axi_rd_ready(ready4),
      .axi_rd_addr(a4), .axi_rd_len(l4), .rd_done(done4),
      .busy(busy4), .proto_err(err4)
   );

   multichannel_rd_rr_arbiter #(.CH_NUM(8), .ADDR_W(30), .LEN_W(8)) dut8 (
      .clk(clk), .rst(rst), .rd_req(req8), .rd_addr(addr8), .rd_len(len8),
      .rd_grant(g8), .axi_rd_start(st8), .axi_rd_ready(ready8),
      .axi_rd_addr(a8), .axi_rd_len(l8), .rd_done(done8),
      .busy(busy8), .proto_err(err8)
   );

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference model: phase 0=idle, 1=command pending, 2=burst in flight
   int          m_phase, m_ptr, m_win;
   logic        m_start, m_err;
   logic [29:0] m_addr;
   logic [7:0]  m_len;

   task automatic model_reset();
      m_phase = 0; m_ptr = 0; m_win = 0;
      m_start = 1'b0; m_err = 1'b0; m_addr = '0; m_len = '0;
   endtask

   task automatic model_step();
      bit found;
      int c;
      if (rst) begin
         model_reset();
      end else begin
         if (done4 && m_phase != 2) m_err = 1'b1;
         case (m_phase)
            0: if (req4 != 0) begin
               found = 0;
               for (int k = 0; k < 4; k++) begin
                  c = (m_ptr + k) % 4;
                  if (!found && req4[c]) begin found = 1; m_win = c; end
               end
               m_addr  = addr4[m_win*30 +: 30];
               m_len   = len4[m_win*8 +: 8];
               m_start = 1'b1;
               m_phase = 1;
            end
            1: if (ready4) begin m_start = 1'b0; m_phase = 2; end
            default: if (done4) begin m_ptr = (m_win + 1) % 4; m_phase = 0; end
         endcase
      end
   endtask

   task automatic tick();
      logic [3:0] eg;
      model_step();
      @(posedge clk);
      #1;
      eg = (m_phase == 0) ? 4'b0 : 4'(1 << m_win);
      chk("grant", g4, eg);
      chk("start", st4, m_start);
      chk("addr", a4, m_addr);
      chk("len", l4, m_len);
      chk("busy", busy4, m_phase != 0);
      chk("perr", err4, m_err);
      chk("xfree8", $isunknown({g8, st8, a8, l8, busy8, err8}), 1'b0);
   endtask

   // One full burst on the 4-channel DUT; returns the grant seen with start
   task automatic run_burst(input int wc, output logic [3:0] g);
      int t;
      t = 0;
      while (!st4 && t < 20) begin tick(); t++; end
      if (!st4) chk("start_timeout", 1'b0, 1'b1);
      g = g4;
      tick();
      repeat (wc) tick();
      done4 = 1'b1;
      tick();
      done4 = 1'b0;
      chk("bubble", {busy4, g4}, 5'b0);
   endtask

   logic [3:0]  g;
   logic [29:0] orig;
   logic [3:0]  exp2 [6] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2};
   logic [7:0]  exp8 [4] = '{8'h01, 8'h80, 8'h01, 8'h80};

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      req4 = '0; ready4 = 1'b0; done4 = 1'b0; len4 = '0;
      req8 = '0; ready8 = 1'b0; done8 = 1'b0; addr8 = '0; len8 = '0;
      for (int i = 0; i < 4; i++) begin
         addr4[i*30 +: 30] = 30'($urandom);
         len4[i*8 +: 8]    = 8'($urandom);
      end
      for (int i = 0; i < 8; i++) begin
         addr8[i*30 +: 30] = 30'($urandom);
         len8[i*8 +: 8]    = 8'($urandom);
      end
      model_reset();
      tick(); tick();
      rst = 1'b0;
      tick();

      // single request: one-cycle latency, ptr moves to 3 afterwards
      req4 = 4'b0100; ready4 = 1'b1;
      tick();
      chk("t1_grant", g4, 4'b0100);
      chk("t1_start", st4, 1'b1);
      chk("t1_addr", a4, addr4[60 +: 30]);
      req4 = 4'b0000;
      repeat (4) tick();
      done4 = 1'b1; tick(); done4 = 1'b0;
      req4 = 4'b1111;
      run_burst(1, g);
      chk("t1_ptr3", g, 4'b1000);

      // all requesting: strict rotation
      for (int b = 0; b < 6; b++) begin
         run_burst(b % 3, g);
         chk("t2_order", g, exp2[b]);
      end

      // pointer wrap from 3 to 0
      req4 = 4'b0100;
      run_burst(0, g);
      chk("t3_pre", g, 4'b0100);
      req4 = 4'b1001;
      run_burst(1, g);
      chk("t3_ch3", g, 4'b1000);
      run_burst(1, g);
      chk("t3_ch0", g, 4'b0001);

      // backpressure with request withdrawn and address changed mid-command
      req4 = 4'b0001; ready4 = 1'b0;
      tick();
      orig = addr4[29:0];
      chk("t4_grant", g4, 4'b0001);
      addr4[29:0] = ~orig;
      req4 = 4'b0000;
      repeat (4) begin
         tick();
         chk("t4_hold", st4, 1'b1);
         chk("t4_addr", a4, orig);
      end
      ready4 = 1'b1;
      tick();
      chk("t4_accepted", {st4, busy4}, 2'b01);
      tick();
      done4 = 1'b1; tick(); done4 = 1'b0;
      chk("t4_done", g4, 4'b0);

      // rd_done while idle, then async reset mid-burst
      done4 = 1'b1; tick(); done4 = 1'b0;
      chk("t5_perr", err4, 1'b1);
      tick(); tick();
      chk("t5_sticky", {err4, busy4, g4}, 6'b100000);
      req4 = 4'b0010;
      tick(); tick();
      chk("t5_inwait", {busy4, g4}, 5'b10010);
      req4 = 4'b0000;
      #2 rst = 1'b1;
      #1;
      chk("t5_async_rst", {g4, st4, a4, l4, busy4, err4}, '0);
      model_reset();
      tick();
      rst = 1'b0;
      tick();

      // randomized traffic including spurious rd_done
      for (int c = 0; c < 400; c++) begin
         req4   = 4'($urandom);
         ready4 = ($urandom_range(0, 3) != 0);
         done4  = ($urandom_range(0, 5) == 0);
         for (int i = 0; i < 4; i++) begin
            addr4[i*30 +: 30] = 30'($urandom);
            len4[i*8 +: 8]    = 8'($urandom);
         end
         tick();
      end
      req4 = '0; done4 = 1'b0; ready4 = 1'b1;
      tick();

      // 8 channels, channels 0 and 7 alternate
      req8 = 8'h81; ready8 = 1'b1;
      for (int b = 0; b < 4; b++) begin
         int t;
         t = 0;
         while (!st8 && t < 20) begin tick(); t++; end
         chk("t6_start8", st8, 1'b1);
         chk("t6_order8", g8, exp8[b]);
         chk("t6_addr8", a8, (g8 == 8'h01) ? addr8[0 +: 30] : addr8[210 +: 30]);
         tick(); tick();
         done8 = 1'b1; tick(); done8 = 1'b0;
         chk("t6_bubble8", {busy8, g8}, 9'b0);
      end
      req8 = '0;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
